// File: rtl/led_arb.sv
// led_arb: round-robin time-sharing of 8 board LEDs between 4 requesters,
// one slice of HOLD cycles per grant, with live LED updates from the holder.
module led_arb #(
  parameter logic [31:0] HOLD = 32'd25_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [31:0] data,
  output logic [3:0]  gnt,
  output logic [7:0]  leds,
  output logic        busy
);
  typedef enum logic {IDLE, SHOW} state_t;
  state_t      state, state_nx;
  logic [1:0]  cur, cur_nx, win;
  logic [31:0] cnt, cnt_nx;
  logic [3:0]  gnt_nx;
  logic [7:0]  leds_nx;
  logic        grant;
  // Descending loop so the nearest requester after cur wins; cur itself is last.
  always_comb begin
    win = cur;
    for (int k = 3; k >= 0; k--)
      if (req[cur + 2'(k + 1)]) win = cur + 2'(k + 1);
  end
  always_comb begin
    state_nx = state;
    cur_nx   = cur;
    cnt_nx   = cnt;
    gnt_nx   = gnt;
    leds_nx  = leds;
    grant    = state == IDLE ? |req : (req[cur] && cnt == '0);
    if (state == SHOW && !req[cur]) begin
      state_nx = IDLE;
      gnt_nx   = '0;
      cnt_nx   = '0;
    end else if (grant) begin
      state_nx = SHOW;
      cur_nx   = win;
      gnt_nx   = 4'b0001 << win;
      leds_nx  = data[8*win +: 8];
      cnt_nx   = HOLD - 32'd1;
    end else if (state == SHOW) begin
      cnt_nx  = cnt - 32'd1;
      leds_nx = data[8*cur +: 8];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cur   <= 2'd3;
      cnt   <= '0;
      gnt   <= '0;
      leds  <= '0;
    end else begin
      state <= state_nx;
      cur   <= cur_nx;
      cnt   <= cnt_nx;
      gnt   <= gnt_nx;
      leds  <= leds_nx;
    end
  end
  assign busy = state == SHOW;
endmodule

// File: tb/tb_led_arb.sv
// tb_led_arb: scoreboard bench driving HOLD=4 and HOLD=1 instances with shared
// directed and random stimulus, checked against a slice-level reference model.
module tb_led_arb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] data = '0;
  logic [3:0]  gnt4, gnt1;
  logic [7:0]  leds4, leds1;
  logic        busy4, busy1;
  int total = 0;
  int bad = 0;

  typedef struct packed {logic [3:0] g; logic [7:0] l; logic b;} exp_t;
  exp_t q4[$], q1[$];

  // Reference model state per instance: 0 -> HOLD=4, 1 -> HOLD=1
  int  hold[2] = '{4, 1};
  bit  act[2];
  int  owner[2];
  int  left[2];
  logic [7:0] shown[2];

  led_arb #(.HOLD(32'd4)) dut4 (.clk(clk), .rst_n(rst_n), .req(req), .data(data),
                                .gnt(gnt4), .leds(leds4), .busy(busy4));
  led_arb #(.HOLD(32'd1)) dut1 (.clk(clk), .rst_n(rst_n), .req(req), .data(data),
                                .gnt(gnt1), .leds(leds1), .busy(busy1));

  always #5 clk = ~clk;

  function automatic logic [7:0] slice(input logic [31:0] d, input int i);
    return d[8*i +: 8];
  endfunction

  // Advance one instance by one clock edge from the spec's slice rules
  function automatic exp_t model(input int m);
    if (!rst_n) begin
      act[m] = 0; owner[m] = 3; left[m] = 0; shown[m] = 8'h00;
    end else if (act[m] && !req[owner[m]]) begin
      act[m] = 0;
    end else if (act[m] && left[m] > 0) begin
      left[m]--;
      shown[m] = slice(data, owner[m]);
    end else if (req != 4'b0000) begin
      for (int k = 1; k <= 4; k++)
        if (req[(owner[m] + k) % 4]) begin
          owner[m] = (owner[m] + k) % 4;
          break;
        end
      act[m] = 1;
      left[m] = hold[m] - 1;
      shown[m] = slice(data, owner[m]);
    end
    return '{g: act[m] ? 4'(1 << owner[m]) : 4'b0000, l: shown[m], b: act[m]};
  endfunction

  task automatic step(input logic r, input logic [3:0] rq, input logic [31:0] d);
    @(negedge clk);
    rst_n = r;
    req = rq;
    data = d;
    q4.push_back(model(0));
    q1.push_back(model(1));
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (q4.size() > 0) begin
      exp_t e;
      e = q4.pop_front();
      check("gnt_h4", 32'(gnt4), 32'(e.g));
      check("leds_h4", 32'(leds4), 32'(e.l));
      check("busy_h4", 32'(busy4), 32'(e.b));
      check("onehot_h4", 32'($onehot0(gnt4)), 32'd1);
    end
    if (q1.size() > 0) begin
      exp_t e;
      e = q1.pop_front();
      check("gnt_h1", 32'(gnt1), 32'(e.g));
      check("leds_h1", 32'(leds1), 32'(e.l));
      check("busy_h1", 32'(busy1), 32'(e.b));
      check("onehot_h1", 32'($onehot0(gnt1)), 32'd1);
    end
  end

  initial begin
    logic [3:0] r;
    logic [31:0] d;
    repeat (2) step(1'b0, 4'b0000, 32'h0);
    // single requester with continuous regrant
    repeat (10) step(1'b1, 4'b0100, 32'h00A5_0000);
    // all requesting: full rotation, data tracked live
    repeat (20) step(1'b1, 4'b1111, 32'h4433_2211);
    // granted 0 with data changes on holder and on a bystander
    repeat (3) step(1'b0, 4'b0000, 32'h0);
    step(1'b1, 4'b0001, 32'h0000_0011);
    step(1'b1, 4'b0001, 32'h0000_0022);
    step(1'b1, 4'b0001, 32'h0000_7722);
    step(1'b1, 4'b1010, 32'h0000_7722);
    // requester 1 granted then dropped mid-slice while 3 waits
    step(1'b1, 4'b1010, 32'h0000_6600);
    step(1'b1, 4'b1010, 32'h0000_6600);
    step(1'b1, 4'b1000, 32'h5A00_6600);
    repeat (3) step(1'b1, 4'b1000, 32'h5A00_0000);
    // reset mid-slice, then release with two requesters
    step(1'b0, 4'b1000, 32'h5A00_0000);
    repeat (3) step(1'b1, 4'b1001, 32'h5A00_00C3);
    repeat (8) step(1'b1, 4'b0101, 32'h0099_0033);
    // random phase: sticky requests with occasional flips, rare resets
    r = 4'($urandom);
    for (int i = 0; i < 600; i++) begin
      r ^= 4'($urandom & $urandom & $urandom);
      d = $urandom;
      step(($urandom_range(0, 49) != 0), r, d);
    end
    @(posedge clk);
    #3;
    check("q4_drained", 32'(q4.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
